// File: rtl/store_unit_pkg.sv
// store_unit_pkg: funct3 encodings shared with the load select, and store fault causes
package store_unit_pkg;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef enum logic [1:0] {
        FC_ILLEGAL  = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_BUS_ERR  = 2'd2,
        FC_TIMEOUT  = 2'd3
    } store_fault_e;
endpackage

// File: rtl/store_unit_if.sv
// store_unit_if: req/gnt + response write bus between the store unit and memory
interface store_unit_if;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid;
    logic        mem_err;
    modport master (output mem_req, mem_addr, mem_wdata, mem_be, input mem_gnt, mem_rvalid, mem_err);
    modport slave (input mem_req, mem_addr, mem_wdata, mem_be, output mem_gnt, mem_rvalid, mem_err);
endinterface

// File: rtl/store_unit_align.sv
// store_align: lane-aligns store data and byte enables, flags illegal width and misalignment
module store_align
    import store_unit_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic        illegal
);
    assign be = funct3 == F3_SB ? 4'b0001 << addr : funct3 == F3_SH ? 4'b0011 << addr : 4'b1111;
    assign wdata = funct3 == F3_SB ? {4{data[7:0]}} : funct3 == F3_SH ? {2{data[15:0]}} : data;
    assign illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
    assign misaligned = (funct3 == F3_SH && addr[0]) || (funct3 == F3_SW && addr != 2'b00);
endmodule

// File: rtl/store_unit.sv
// store_unit: accepts one SB/SH/SW, runs the bus write handshake, reports completion or fault
module store_unit
    import store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               st_valid,
    output logic               st_ready,
    input  logic [31:0]        st_addr,
    input  logic [31:0]        st_data,
    input  logic [2:0]         st_funct3,
    store_unit_if.master       mem,
    output logic               stall,
    output logic               st_done,
    output logic               fault_valid,
    output logic [1:0]         fault_cause,
    output logic [31:0]        fault_addr
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_FAULT} state_e;
    state_e           state, state_nx;
    store_fault_e     cause_q, cause_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q, wdata_q, fault_addr_q, wdata;
    logic [3:0]       be_q, be;
    logic             misaligned, illegal, accept, timeout;
    store_align u_align (
        .addr(st_addr[1:0]),
        .data(st_data),
        .funct3(st_funct3),
        .be(be),
        .wdata(wdata),
        .misaligned(misaligned),
        .illegal(illegal)
    );
    assign accept = state == S_IDLE && st_valid;
    // >= so a grant on the last allowed cycle still leaves one RESP cycle to answer
    assign timeout = cnt >= CNT_W'(TIMEOUT_CYCLES - 1);
    always_comb begin
        state_nx = state;
        cause_nx = cause_q;
        case (state)
            S_IDLE: if (st_valid) begin
                state_nx = illegal || misaligned ? S_FAULT : S_REQ;
                cause_nx = illegal ? FC_ILLEGAL : FC_MISALIGN;
            end
            S_REQ: if (mem.mem_gnt) state_nx = S_RESP;
                else if (timeout) begin
                    state_nx = S_FAULT;
                    cause_nx = FC_TIMEOUT;
                end
            S_RESP: if (mem.mem_rvalid) begin
                    state_nx = mem.mem_err ? S_FAULT : S_IDLE;
                    cause_nx = FC_BUS_ERR;
                end else if (timeout) begin
                    state_nx = S_FAULT;
                    cause_nx = FC_TIMEOUT;
                end
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cause_q      <= FC_ILLEGAL;
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            fault_addr_q <= '0;
        end else begin
            state   <= state_nx;
            cause_q <= cause_nx;
            cnt     <= accept ? '0 : (state == S_REQ || state == S_RESP) ? cnt + 1'b1 : cnt;
            if (accept) begin
                addr_q       <= {st_addr[31:2], 2'b00};
                wdata_q      <= wdata;
                be_q         <= be;
                fault_addr_q <= st_addr;
            end
        end
    end
    assign st_ready      = state == S_IDLE;
    assign stall         = state != S_IDLE;
    assign mem.mem_req   = state == S_REQ;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;
    assign st_done       = state == S_RESP && mem.mem_rvalid && !mem.mem_err;
    assign fault_valid   = state == S_FAULT;
    assign fault_cause   = fault_valid ? cause_q : 2'b00;
    assign fault_addr    = fault_addr_q;
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed and randomized stores checked against a transaction-level model
module tb_store_unit;
    localparam int T = 8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [2:0]  st_funct3 = '0;
    logic        stall, st_done, fault_valid;
    logic [1:0]  fault_cause;
    logic [31:0] fault_addr;
    int          n_cmp = 0;
    int          n_err = 0;
    store_unit_if bus ();
    store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .st_valid(st_valid),
        .st_ready(st_ready),
        .st_addr(st_addr),
        .st_data(st_data),
        .st_funct3(st_funct3),
        .mem(bus),
        .stall(stall),
        .st_done(st_done),
        .fault_valid(fault_valid),
        .fault_cause(fault_cause),
        .fault_addr(fault_addr)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic fault_cycle(input logic [31:0] a, input int cause);
        #1;
        check("fault_valid", fault_valid, 1);
        check("fault_cause", fault_cause, cause);
        check("fault_addr", fault_addr, a);
        check("fault_req", bus.mem_req, 0);
        check("fault_done", st_done, 0);
        check("fault_stall", stall, 1);
        @(negedge clk);
        #1;
        check("fault_once", fault_valid, 0);
        check("fault_ready", st_ready, 1);
    endtask
    // Caller is at a negedge with the unit idle; returns at a negedge with the unit idle
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                             input int gd, input int rd, input logic e);
        int nb, req_n, resp_n, lim, cause;
        logic bad, ok;
        logic [3:0] be;
        logic [31:0] wd;
        bad = 1'b0;
        ok = 1'b0;
        cause = 0;
        nb = f3 <= 3'd2 ? 1 << f3 : 0;
        be = '0;
        wd = '0;
        if (nb == 0) bad = 1'b1;
        else if (a % nb != 0) begin bad = 1'b1; cause = 1; end
        if (nb != 0)
            for (int i = 0; i < 4; i++) begin
                be[i] = i >= int'(a[1:0]) && i < int'(a[1:0]) + nb;
                wd[8*i +: 8] = d[8*(i % nb) +: 8];
            end
        check("idle_ready", st_ready, 1);
        st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
        @(negedge clk);
        st_valid = 1'b0; st_addr = $urandom; st_data = $urandom; st_funct3 = 3'($urandom);
        if (bad) begin
            fault_cycle(a, cause);
            return;
        end
        req_n = gd < T ? gd + 1 : T;
        resp_n = 0;
        cause = 3;
        if (gd < T) begin
            lim = T - req_n > 1 ? T - req_n : 1;
            if (rd < lim) begin
                resp_n = rd + 1;
                ok = !e;
                cause = 2;
            end else resp_n = lim;
        end
        for (int i = 0; i < req_n + resp_n; i++) begin
            bus.mem_gnt = i == gd;
            bus.mem_rvalid = i < req_n ? 1'($urandom) : i == req_n + rd;
            bus.mem_err = i == req_n + rd ? e : 1'($urandom);
            #1;
            check("req", bus.mem_req, i < req_n);
            check("stall", stall, 1);
            check("done", st_done, ok && i == req_n + resp_n - 1);
            check("no_fault", fault_valid, 0);
            if (i < req_n) begin
                check("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
                check("mem_be", bus.mem_be, be);
                check("mem_wdata", bus.mem_wdata, wd);
            end
            @(negedge clk);
        end
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
        if (!ok) fault_cycle(a, cause);
        else begin
            #1;
            check("done_once", st_done, 0);
            check("post_stall", stall, 0);
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        logic [2:0] f3;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", st_ready, 1);
        check("rst_req", bus.mem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_done", st_done, 0);
        check("rst_fault", fault_valid, 0);
        check("rst_cause", fault_cause, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_be", bus.mem_be, 0);
        check("rst_faddr", fault_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_store(32'h1000, 32'hDEADBEEF, 3'b010, 2, 0, 1'b0);
        run_store(32'h2003, 32'h000000A5, 3'b000, 0, 1, 1'b0);
        run_store(32'h2002, 32'h00001234, 3'b001, 1, 0, 1'b0);
        run_store(32'h2001, 32'h55667788, 3'b001, 0, 0, 1'b0);
        run_store(32'h2002, 32'h55667788, 3'b010, 0, 0, 1'b0);
        run_store(32'h2000, 32'h55667788, 3'b011, 0, 0, 1'b0);
        run_store(32'h3000, 32'hCAFEF00D, 3'b010, 0, 1, 1'b1);
        run_store(32'h3004, 32'h0BADF00D, 3'b010, 1, 0, 1'b0);
        run_store(32'h4000, 32'h11111111, 3'b010, 100, 0, 1'b0);
        bus.mem_rvalid = 1'b1; bus.mem_err = 1'b1;
        #1;
        check("stray_done", st_done, 0);
        check("stray_fault", fault_valid, 0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
        #1;
        check("stray_idle", st_ready, 1);
        check("stray_fault2", fault_valid, 0);
        run_store(32'h4004, 32'h22222222, 3'b010, T - 1, 0, 1'b0);
        run_store(32'h4008, 32'h33333333, 3'b010, T - 1, 1, 1'b0);
        run_store(32'h400C, 32'h44444444, 3'b010, 3, 3, 1'b0);
        run_store(32'h4010, 32'h55555555, 3'b010, 3, 4, 1'b0);
        st_valid = 1'b1; st_addr = 32'h5000; st_data = 32'h12345678; st_funct3 = 3'b010;
        @(negedge clk);
        st_valid = 1'b0; bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", st_ready, 1);
        check("mid_rst_req", bus.mem_req, 0);
        check("mid_rst_done", st_done, 0);
        check("mid_rst_fault", fault_valid, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_addr", bus.mem_addr, 0);
        run_store(32'h6001, 32'h000000C3, 3'b000, 1, 1, 1'b0);
        for (int n = 0; n < 60; n++) begin
            f3 = 3'($urandom_range(0, 3));
            if (f3 == 3'd3) f3 = 3'($urandom_range(3, 7));
            run_store($urandom, $urandom, f3, $urandom_range(0, 9), $urandom_range(0, 9),
                      $urandom_range(0, 3) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
